rom_fetch_arbiter: RTL and testbench

ROM_FETCH_ARBITER -- requirements
Module: rom_fetch_arbiter

---
 rtl/rom_fetch_arbiter_pkg.sv | 24 ++
 rtl/rom_fetch_arbiter_grant.sv | 45 ++++
 rtl/rom_fetch_arbiter.sv | 136 +++++++++++++
 tb/tb_rom_fetch_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_fetch_arbiter_pkg.sv
// Shared definitions for the ROM fetch arbiter: FSM state encoding,
// request size encoding and the size-to-byte-count mapping.
package rom_fetch_arbiter_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Request size encoding; the unused code 3 behaves as a word
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Number of ROM bytes a request of the given size fetches
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rom_fetch_arbiter_grant.sv
// rom_arb_grant: picks which requester is served next.
// Build option ROM_ARB_ROUND_ROBIN_EN: when defined, simultaneous requests
// go to the port not granted last (pointer register, reset prefers port 0);
// when undefined, port 0 (instruction fetch) always wins and no pointer exists.
module rom_arb_grant (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_valid,
  input  logic       grant_en,   // arbiter is idle and can accept a grant
  output logic       grant_vld,  // some requester is asking
  output logic       grant_id    // index of the selected requester
);

  assign grant_vld = |req_valid;

`ifdef ROM_ARB_ROUND_ROBIN_EN
  // Preferred port for the next tie; port 0 after reset
  logic r_ptr;

  // Tie goes to the pointer, otherwise the single active requester wins
  always_comb begin
    grant_id = (&req_valid) ? r_ptr : req_valid[1];
  end

  // Pointer moves to the other port whenever a grant is actually issued
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= 1'b0;
    end else if (grant_en && grant_vld) begin
      r_ptr <= ~grant_id;
    end
  end
`else
  logic w_unused;

  // Fixed priority: port 1 only when port 0 is quiet
  always_comb begin
    grant_id = req_valid[1] & ~req_valid[0];
  end

  // Clock, reset and enable only matter for the pointer build
  assign w_unused = ^{clk, reset_n, grant_en};
`endif

endmodule

// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter: shares one byte-wide ROM between instruction fetch
// (port 0) and data load (port 1). A granted request reads 1, 2 or 4 bytes
// little-endian starting at any byte address, then pulses done to its owner.
// Build option ROM_ARB_ROUND_ROBIN_EN selects round-robin arbitration in
// rom_arb_grant; without it port 0 has fixed priority.
module rom_fetch_arbiter
  import rom_fetch_arbiter_pkg::*;
#(
  parameter int depth = 512  // ROM depth in 32-bit words
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req_valid,
  input  logic [31:0] req_address0,
  input  logic [31:0] req_address1,
  input  logic [1:0]  req_size0,
  input  logic [1:0]  req_size1,
  output logic [1:0]  req_ready,
  output logic [1:0]  done,
  output logic [31:0] rd_data,
  output logic        rd_error,
  output logic [31:0] rom_address,
  input  logic [7:0]  rom_read_data,
  input  logic        rom_illegal_address
);

  // The ROM itself flags out-of-range addresses; depth only has to be sane
  if (depth < 1) begin : g_depth_check
    $error("rom_fetch_arbiter: depth must be at least 1");
  end

  logic [1:0]  r_state;
  logic        r_owner;
  logic [31:0] r_addr;
  logic [2:0]  r_len;
  logic [1:0]  r_idx;
  logic [31:0] r_data;
  logic        r_error;
  logic [31:0] r_rom_addr;

  logic        w_idle;
  logic        w_grant_vld;
  logic        w_grant_id;
  logic        w_grant_take;
  logic        w_last;
  logic [31:0] w_sel_addr;
  logic [1:0]  w_sel_size;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_grant_take = w_idle && w_grant_vld;
  assign w_sel_addr   = w_grant_id ? req_address1 : req_address0;
  assign w_sel_size   = w_grant_id ? req_size1 : req_size0;
  assign w_last       = ({1'b0, r_idx} == (r_len - 3'd1));

  rom_arb_grant u_grant (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .grant_en  (w_idle),
    .grant_vld (w_grant_vld),
    .grant_id  (w_grant_id)
  );

  // Acceptance pulse only while idle; reset suppresses it immediately
  always_comb begin
    req_ready = 2'b00;
    if (reset_n && w_grant_take) begin
      req_ready[w_grant_id] = 1'b1;
    end
  end

  // Completion pulse is the single DONE cycle, steered to the owner
  always_comb begin
    done = 2'b00;
    if (r_state == ST_DONE) begin
      done[r_owner] = 1'b1;
    end
  end

  assign rd_data     = r_data;
  assign rd_error    = r_error;
  assign rom_address = r_rom_addr;

  // Transaction FSM: grant/latch, byte-by-byte capture, one-cycle completion
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_owner    <= 1'b0;
      r_addr     <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_data     <= '0;
      r_error    <= 1'b0;
      r_rom_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_vld) begin
            r_state    <= ST_READ;
            r_owner    <= w_grant_id;
            r_addr     <= w_sel_addr;
            r_len      <= size_to_bytes(w_sel_size);
            r_idx      <= 2'd0;
            r_data     <= '0;
            r_error    <= 1'b0;
            r_rom_addr <= w_sel_addr;
          end
        end
        ST_READ: begin
          if (rom_illegal_address) begin
            // Abort: nothing partial is ever returned
            r_data  <= '0;
            r_error <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_data[{r_idx, 3'b000} +: 8] <= rom_read_data;
            if (w_last) begin
              // Address stays on the final byte until the next grant
              r_state <= ST_DONE;
            end else begin
              r_idx      <= r_idx + 2'd1;
              r_rom_addr <= r_addr + {30'd0, r_idx + 2'd1};
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Self-checking bench for rom_fetch_arbiter with a byte-array ROM model and
// a transaction-level reference (bytes fetched, data, error, completion
// cycle). Honours ROM_ARB_ROUND_ROBIN_EN for the expected arbitration order.
module tb_rom_fetch_arbiter;

  localparam int DEPTH  = 512;
  localparam int NBYTES = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [31:0] req_address0, req_address1;
  logic [1:0]  req_size0, req_size1;
  logic [1:0]  req_ready;
  logic [1:0]  done;
  logic [31:0] rd_data;
  logic        rd_error;
  logic [31:0] rom_address;
  logic [7:0]  rom_read_data;
  logic        rom_illegal_address;

  logic [7:0]  rom_mem [NBYTES];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_grant = 1;  // model: port granted last; 1 after reset so port 0 is preferred

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational byte-wide ROM
  always_comb begin
    rom_illegal_address = (rom_address >= 32'(NBYTES));
    rom_read_data = rom_illegal_address ? 8'hEE : rom_mem[rom_address[10:0]];
  end

  rom_fetch_arbiter #(.depth(DEPTH)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .req_valid           (req_valid),
    .req_address0        (req_address0),
    .req_address1        (req_address1),
    .req_size0           (req_size0),
    .req_size1           (req_size1),
    .req_ready           (req_ready),
    .done                (done),
    .rd_data             (rd_data),
    .rd_error            (rd_error),
    .rom_address         (rom_address),
    .rom_read_data       (rom_read_data),
    .rom_illegal_address (rom_illegal_address)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the requested bytes, stop at the first out-of-range one
  function automatic void model(input logic [31:0] addr, input logic [1:0] size,
                                output logic [31:0] data, output logic err,
                                output int nbytes, output logic [31:0] last_addr);
    int len;
    logic [31:0] a;
    len = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    data = '0; err = 1'b0; nbytes = 0; last_addr = addr;
    for (int i = 0; i < len; i++) begin
      a = addr + 32'(i);
      last_addr = a;
      nbytes = i + 1;
      if (a >= 32'(NBYTES)) begin
        err = 1'b1;
        data = '0;
        break;
      end
      data[8*i +: 8] = rom_mem[a[10:0]];
    end
  endfunction

  function automatic int exp_grant(input logic [1:0] v);
`ifdef ROM_ARB_ROUND_ROBIN_EN
    if (v == 2'b11) return last_grant ^ 1;
`else
    if (v == 2'b11) return 0;
`endif
    return (v[1] && !v[0]) ? 1 : 0;
  endfunction

  // One single-port transaction; starts and ends just after a falling edge, idle
  task automatic run_txn(input int port, input logic [31:0] addr, input logic [1:0] size,
                         input bit drop, input string tag);
    logic [31:0] edata, elast;
    logic eerr;
    int n, waited, k;
    model(addr, size, edata, eerr, n, elast);
    if (port == 0) begin req_address0 = addr; req_size0 = size; end
    else begin req_address1 = addr; req_size1 = size; end
    req_valid = 2'b00;
    req_valid[port] = 1'b1;
    #1;
    waited = 0;
    while (req_ready == 2'b00 && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    check({tag, " grant"}, 32'(req_ready), 32'(2'b01 << port));
    last_grant = port;
    @(negedge clk);
    if (drop) req_valid = 2'b00;
    #1;
    k = 1;
    while (done == 2'b00 && k < 12) begin
      check({tag, " ready_busy"}, 32'(req_ready), 32'd0);
      @(negedge clk); #1; k++;
    end
    check({tag, " latency"}, 32'(k), 32'(n + 1));
    check({tag, " done"}, 32'(done), 32'(2'b01 << port));
    check({tag, " data"}, rd_data, edata);
    check({tag, " error"}, 32'(rd_error), 32'(eerr));
    check({tag, " rom_addr"}, rom_address, elast);
    req_valid = 2'b00;
    @(negedge clk); #1;
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " data_hold"}, rd_data, edata);
    check({tag, " error_hold"}, 32'(rd_error), 32'(eerr));
    check({tag, " addr_hold"}, rom_address, elast);
    $display("txn %s port=%0d addr=%08h size=%0d data=%08h err=%0b bytes=%0d",
             tag, port, addr, size, rd_data, rd_error, n);
  endtask

  initial begin
    logic [31:0] a0, a1, addr;
    int gid, waited, k, prev_cyc, port;
    logic [1:0] size;
    bit drop;

    for (int i = 0; i < NBYTES; i++) rom_mem[i] = 8'($urandom);
    rom_mem[0] = 8'h13; rom_mem[1] = 8'h05; rom_mem[2] = 8'h10; rom_mem[3] = 8'h00;

    // Reset state, with a request pending to prove req_ready is held off
    reset_n = 1'b0;
    req_valid = 2'b01;
    req_address0 = '0; req_address1 = '0; req_size0 = '0; req_size1 = '0;
    #2;
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst rd_data", rd_data, 32'd0);
    check("rst rd_error", 32'(rd_error), 32'd0);
    check("rst rom_addr", rom_address, 32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    last_grant = 1;
    #1;

    // Directed transactions
    run_txn(0, 32'h0, 2'd2, 1'b0, "word0");
    check("word0 const", rd_data, 32'h00100513);
    run_txn(1, 32'h2, 2'd1, 1'b0, "half2");
    check("half2 const", rd_data, 32'h00000010);
    run_txn(0, 32'h7FE, 2'd2, 1'b0, "word7fe");
    check("word7fe const_err", 32'(rd_error), 32'd1);
    run_txn(0, 32'h40, 2'd2, 1'b1, "drop");
    run_txn(1, 32'h101, 2'd3, 1'b0, "size3mis");

    // Both ports requesting continuously
    a0 = 32'h10; a1 = 32'h20;
    req_address0 = a0; req_size0 = 2'd0;
    req_address1 = a1; req_size1 = 2'd0;
    req_valid = 2'b11;
    #1;
    prev_cyc = -1;
    for (int g = 0; g < 4; g++) begin
      waited = 0;
      while (req_ready == 2'b00 && waited < 10) begin
        @(negedge clk); #1; waited++;
      end
      gid = exp_grant(2'b11);
      check("cont grant", 32'(req_ready), 32'(2'b01 << gid));
      if (prev_cyc >= 0) check("cont spacing", 32'(cyc - prev_cyc), 32'd3);
      prev_cyc = cyc;
      last_grant = gid;
      k = 0;
      do begin
        @(negedge clk); #1; k++;
        if (done == 2'b00) check("cont ready_busy", 32'(req_ready), 32'd0);
      end while (done == 2'b00 && k < 10);
      check("cont done", 32'(done), 32'(2'b01 << gid));
      check("cont data", rd_data, {24'd0, rom_mem[(gid == 0) ? a0[10:0] : a1[10:0]]});
      $display("txn cont grant=%0d data=%08h", gid, rd_data);
      @(negedge clk); #1;
    end
    req_valid = 2'b00;
    @(negedge clk); @(negedge clk); #1;

    // Reset pulse during the third byte of a word read
    req_address0 = 32'h0; req_size0 = 2'd2;
    req_valid = 2'b01;
    #1;
    waited = 0;
    while (req_ready == 2'b00 && waited < 10) begin
      @(negedge clk); #1; waited++;
    end
    check("rstmid grant", 32'(req_ready), 32'd1);
    @(negedge clk); req_valid = 2'b00;  // T+1
    @(negedge clk);                     // T+2
    @(negedge clk); #1;                 // T+3: third byte on the bus
    check("rstmid partial", rd_data, 32'h00000513);
    check("rstmid addr", rom_address, 32'h2);
    reset_n = 1'b0;
    #1;
    check("rstmid done", 32'(done), 32'd0);
    check("rstmid data", rd_data, 32'd0);
    check("rstmid error", 32'(rd_error), 32'd0);
    check("rstmid rom_addr", rom_address, 32'd0);
    check("rstmid ready", 32'(req_ready), 32'd0);
    #1;
    reset_n = 1'b1;
    last_grant = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      check("rstmid no_done", 32'(done), 32'd0);
    end
    $display("txn rstmid aborted data=%08h", rd_data);
    run_txn(0, 32'h0, 2'd2, 1'b0, "post_rst");

    // Randomized single-port traffic, including range-edge and wrap addresses
    for (int t = 0; t < 24; t++) begin
      port = int'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      drop = bit'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        7, 8:    addr = 32'(NBYTES - 4) + 32'($urandom_range(0, 3));
        9:       addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        default: addr = 32'($urandom_range(0, NBYTES - 1));
      endcase
      run_txn(port, addr, size, drop, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute guard against a stuck run
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
